// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Types and constants shared by the UART transmit-side blocks.
//               The drain FSM state type and the UART data width live here.
// Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_W = 8;

    // Drain FSM of the transmit FIFO
    typedef enum logic [1:0] {
        TXF_IDLE      = 2'd0,
        TXF_LAUNCH    = 2'd1,
        TXF_WAIT_DONE = 2'd2
    } txf_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo_core.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_core
// Description : Power-of-two circular byte FIFO with a separate occupancy
//               counter and a sticky overflow flag.
// Ports       : clk, reset (async, active low)
//               wr_en / wr_data   - enqueue strobe and byte (dropped when full)
//               pop               - dequeue the head entry (ignored when empty)
//               ovf_clr           - clear the sticky overflow flag
//               rd_data           - head-of-FIFO byte, combinational
//               full / empty      - registered-count derived status flags
//               count             - number of stored entries
//               overflow          - sticky: a write was attempted while full
// Revision    : 1.0  initial release
// ============================================================================
module sync_fifo_core
    import uart_pkg::*;
#(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic                   pop,
    input  logic                   ovf_clr,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_W:0]        count,
    output logic                   overflow
);

    localparam logic [ADDR_W:0]   c_full_count = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_cnt_one    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_ptr_one    = ADDR_W'(1);

    logic [UART_DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0]      r_wr_ptr;
    logic [ADDR_W-1:0]      r_rd_ptr;
    logic [ADDR_W:0]        r_count;
    logic                   r_overflow;

    logic                   w_push;
    logic                   w_pop;

    // Flags come straight from the registered count, so there is no
    // combinational path from wr_en to full.
    assign full   = (r_count == c_full_count);
    assign empty  = (r_count == '0);
    assign w_push = wr_en && !full;
    assign w_pop  = pop && !empty;

    // Storage needs no reset: contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase

            // A dropped write has priority over a clear in the same cycle.
            if (wr_en && full) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign rd_data  = r_mem[r_rd_ptr];
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Transmit-side byte buffer in front of the UART. Bytes written
//               by the host are queued in a circular FIFO and handed one at a
//               time to the transmitter over the send / tx_busy handshake.
// Ports       : clk, reset (async, active low)
//               wr_en / wr_data   - host write port
//               ovf_clr           - clear the sticky overflow flag
//               tx_busy           - transmitter frame-in-progress indicator
//               send              - level request to the transmitter
//               tx_data           - byte presented to the transmitter
//               full / empty / count / overflow - FIFO status
// Revision    : 1.0  initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic                   ovf_clr,
    input  logic                   tx_busy,
    output logic                   send,
    output logic [UART_DATA_W-1:0] tx_data,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_W:0]        count,
    output logic                   overflow
);

    txf_state_t             r_state;
    txf_state_t             w_next_state;
    logic [UART_DATA_W-1:0] r_tx_hold;
    logic [UART_DATA_W-1:0] w_head;
    logic                   w_pop;
    logic                   w_empty;

    // The FIFO is popped on the edge where the transmitter acknowledges.
    assign w_pop = (r_state == TXF_LAUNCH) && tx_busy;

    sync_fifo_core #(
        .DEPTH    (DEPTH)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .pop      (w_pop),
        .ovf_clr  (ovf_clr),
        .rd_data  (w_head),
        .full     (full),
        .empty    (w_empty),
        .count    (count),
        .overflow (overflow)
    );

    assign empty = w_empty;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= TXF_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            TXF_IDLE: begin
                // A busy line here belongs to some other sender: keep waiting.
                if (!w_empty && !tx_busy) begin
                    w_next_state = TXF_LAUNCH;
                end
            end
            TXF_LAUNCH: begin
                if (tx_busy) begin
                    w_next_state = TXF_WAIT_DONE;
                end
            end
            TXF_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_next_state = TXF_IDLE;
                end
            end
            default: w_next_state = TXF_IDLE;
        endcase
    end

    // The head byte is captured on entry to LAUNCH; once popped, its slot
    // may be rewritten by the host while the frame is still on the line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_hold <= '0;
        end else if ((r_state == TXF_IDLE) && (w_next_state == TXF_LAUNCH)) begin
            r_tx_hold <= w_head;
        end
    end

    // Output logic
    always_comb begin
        send    = 1'b0;
        tx_data = '0;
        unique case (r_state)
            TXF_LAUNCH: begin
                send    = 1'b1;
                tx_data = w_head;
            end
            TXF_WAIT_DONE: begin
                tx_data = r_tx_hold;
            end
            default: begin
                // Idle with nothing queued shows zero rather than stale data.
                tx_data = w_empty ? '0 : w_head;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo. A queue-based model
//               tracks accepted bytes, occupancy and overflow; a behavioural
//               transmitter answers send requests with random latencies and
//               frame lengths and checks every launched byte in order.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          ovf_clr = 1'b0;
    logic          force_busy = 1'b0;
    logic          line_busy = 1'b0;
    logic          tx_busy;
    logic          send;
    logic [7:0]    tx_data;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;

    assign tx_busy = force_busy | line_busy;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DEPTH    (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .ovf_clr  (ovf_clr),
        .tx_busy  (tx_busy),
        .send     (send),
        .tx_data  (tx_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    int         checks = 0;
    int         errors = 0;

    // Reference model
    logic [7:0] exp_q[$];
    int         m_count = 0;
    bit         m_ovf = 1'b0;
    bit         pop_next = 1'b0;

    // Behavioural transmitter
    bit         auto_tx = 1'b0;
    int         tx_phase = 0;
    int         hi_cnt = 0;
    int         dly = 1;
    int         hold = 1;
    logic [7:0] cap = 8'h00;
    bit         expect_rise = 1'b0;
    int         n_frames = 0;
    int         dly_min = 1, dly_max = 3, len_min = 2, len_max = 6;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic clear_model();
        m_count     = 0;
        m_ovf       = 1'b0;
        pop_next    = 1'b0;
        exp_q.delete();
        tx_phase    = 0;
        line_busy   = 1'b0;
        hi_cnt      = 0;
        expect_rise = 1'b0;
    endtask

    // Model update on each active edge: writes are judged against the
    // occupancy at the start of the cycle, so a same-cycle pop never
    // rescues a write made while full.
    initial forever begin
        bit full_b;
        @(posedge clk);
        if (reset) begin
            full_b = (m_count == DEPTH);
            if (ovf_clr) m_ovf = 1'b0;
            if (wr_en) begin
                if (full_b) begin
                    m_ovf = 1'b1;
                end else begin
                    exp_q.push_back(wr_data);
                    m_count++;
                end
            end
            if (pop_next) begin
                m_count--;
                pop_next = 1'b0;
            end
        end
    end

    // Transmitter: acknowledges a request after it has been seen for
    // 'dly' cycles, then keeps the line busy for 'hold' cycles.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            tx_phase    = 0;
            line_busy   = 1'b0;
            hi_cnt      = 0;
            expect_rise = 1'b0;
        end else begin
            case (tx_phase)
                0: begin
                    if (expect_rise) begin
                        check("b2b_rise", send, 1);
                        expect_rise = 1'b0;
                    end
                    if (send && auto_tx && !force_busy) begin
                        if (hi_cnt == 0) dly = $urandom_range(dly_max, dly_min);
                        hi_cnt++;
                        if (hi_cnt >= dly) begin
                            cap = tx_data;
                            if (exp_q.size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL unexpected_byte actual=%02h required=none", cap);
                            end else begin
                                check("tx_data", cap, exp_q.pop_front());
                            end
                            line_busy = 1'b1;
                            pop_next  = 1'b1;
                            hold      = $urandom_range(len_max, len_min);
                            tx_phase  = 1;
                            hi_cnt    = 0;
                            n_frames++;
                        end
                    end else if (hi_cnt > 0) begin
                        check("send_held", send, 1);
                        hi_cnt = 0;
                    end
                end
                1: begin
                    check("send_dropped", send, 0);
                    check("tx_data_stable", tx_data, cap);
                    hold--;
                    if (hold <= 0) begin
                        line_busy = 1'b0;
                        tx_phase  = 2;
                    end
                end
                default: begin
                    check("send_gap", send, 0);
                    expect_rise = (m_count > 0) && !force_busy;
                    tx_phase    = 0;
                end
            endcase
        end
    end

    // Status monitor: compares FIFO status with the model every cycle.
    initial forever begin
        @(negedge clk);
        #2;
        if (reset) begin
            check("count", count, m_count);
            check("full", full, (m_count == DEPTH));
            check("empty", empty, (m_count == 0));
            check("overflow", overflow, m_ovf);
        end
    end

    task automatic write_byte(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((m_count != 0 || tx_phase != 0 || line_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0 (entries left)", m_count);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int nf0;
        int writes;
        int cyc;
        logic [7:0] d;

        // Reset values while reset is held
        repeat (3) @(negedge clk);
        check("rst_send", send, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        reset = 1'b1;
        @(negedge clk);

        // Reset while in LAUNCH
        auto_tx = 1'b0;
        write_byte(8'hA5);
        check("send_latency_early", send, 0);
        @(negedge clk);
        check("launch_send", send, 1);
        check("launch_data", tx_data, 8'hA5);
        reset = 1'b0;
        clear_model();
        #1;
        check("midrst_send", send, 0);
        check("midrst_empty", empty, 1);
        check("midrst_count", count, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Single byte, request acknowledged after 3 cycles
        auto_tx = 1'b1;
        dly_min = 3; dly_max = 3; len_min = 4; len_max = 4;
        nf0 = n_frames;
        write_byte(8'h55);
        wait_drain(200);
        check("single_frames", n_frames - nf0, 1);

        // Burst of four consecutive writes
        dly_min = 1; dly_max = 3; len_min = 2; len_max = 8;
        nf0 = n_frames;
        for (int i = 1; i <= 4; i++) write_byte(8'(i));
        wait_drain(500);
        check("burst_frames", n_frames - nf0, 4);

        // Fill with a foreign sender holding the line, then overflow
        force_busy = 1'b1;
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            d = 8'($urandom_range(8'hED, 0));
            write_byte(d);
            check("busy_no_send", send, 0);
        end
        check("fill_full", full, 1);
        check("fill_count", count, DEPTH);
        write_byte(8'hEE);
        check("ovf_set", overflow, 1);
        check("ovf_count", count, DEPTH);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_clr", overflow, 0);
        ovf_clr = 1'b1;
        write_byte(8'hEE);
        ovf_clr = 1'b0;
        check("ovf_set_wins", overflow, 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_clr2", overflow, 0);
        check("busy_no_send_end", send, 0);
        nf0 = n_frames;
        force_busy = 1'b0;
        @(negedge clk);
        check("release_send", send, 1);
        wait_drain(2000);
        check("full_frames", n_frames - nf0, DEPTH);

        // Wrap with occupancy held around 3..5, including write+pop cycles
        dly_min = 1; dly_max = 2; len_min = 1; len_max = 3;
        nf0 = n_frames;
        writes = 0;
        cyc = 0;
        while (writes < 40 && cyc < 2000) begin
            if (m_count < 3)       wr_en = 1'b1;
            else if (m_count >= 5) wr_en = 1'b0;
            else                   wr_en = 1'($urandom_range(1, 0));
            wr_data = 8'($urandom);
            if (wr_en) writes++;
            @(negedge clk);
            cyc++;
        end
        wr_en = 1'b0;
        wait_drain(1000);
        check("wrap_frames", n_frames - nf0, 40);

        // Random pressure: long frames, frequent writes, random clears
        dly_min = 1; dly_max = 4; len_min = 1; len_max = 12;
        for (int i = 0; i < 300; i++) begin
            wr_en   = ($urandom_range(3, 0) != 0);
            wr_data = 8'($urandom);
            ovf_clr = ($urandom_range(15, 0) == 0);
            @(negedge clk);
        end
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        wait_drain(2000);

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL global_timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side byte buffer that sits directly upstream of the UART top level. It accepts bytes from a host-side write port into a power-of-two circular FIFO. It drains them one at a time into the UART transmitter through the transmitter's `send` / `data_in` / `tx_busy` handshake. This decouples bursty producers from the baud-rate-limited serial line.

## Interface
Parameters:
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2.
- `ADDR_W`, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- `clk`  in  1  system clock; the UART top level uses the same clock.
- `reset`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write strobe; one byte is accepted per cycle when not full.
- `wr_data`  in  8  byte to enqueue.
- `ovf_clr`  in  1  clears the sticky `overflow` flag.
- `tx_busy`  in  1  from the UART top level; high while a frame is on the line.
- `send`  out  1  to UART `send`; level request, held until `tx_busy` is seen high.
- `tx_data`  out  8  to UART `data_in`; head-of-FIFO byte, stable while `send` is high and while in WAIT_DONE.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `count`  out  ADDR_W+1  number of stored entries, including the byte currently being launched.
- `overflow`  out  1  sticky: a write was attempted while full.

## Operation
- Storage is DEPTH×8 registers, with `wr_ptr`/`rd_ptr` of ADDR_W bits that wrap modulo DEPTH. `count` is a separate ADDR_W+1-bit counter.
- Write: `wr_en && !full` stores `wr_data` at `wr_ptr`, then `wr_ptr`+1.
  - `wr_en && full` drops the byte and sets `overflow`.
  - `full` is the registered value from the start of the cycle. A write while full is dropped even if a pop happens in the same cycle.
- Read FSM, three states:
  - IDLE: if `!empty && !tx_busy`, then `send` goes to 1 and the FSM moves to LAUNCH.
  - LAUNCH: `send` stays 1. When `tx_busy` is sampled 1, `send` goes to 0, the FIFO pops (`rd_ptr`+1, `count`−1), and the FSM moves to WAIT_DONE.
  - WAIT_DONE: when `tx_busy` is sampled 0, the FSM moves to IDLE.
- `tx_data` is driven combinationally from `mem[rd_ptr]` in IDLE/LAUNCH. It is driven from a byte latched on entry to LAUNCH in WAIT_DONE, because the popped slot may be overwritten.
- Simultaneous write and pop (not full): `count` is unchanged and both pointers advance.
- `ovf_clr` and an overflowing write in the same cycle: `overflow` remains 1 (set wins).
- `tx_busy` already high in IDLE (a foreign sender is active): the FSM waits and does not assert `send`.

## Timing
- Reset (async assert, sync-release assumed upstream) gives:
  - `send`=0, `tx_data`=0, `full`=0, `empty`=1, `count`=0, `overflow`=0.
  - Pointers are 0 and the FSM is in IDLE; FIFO contents are don't-care.
- Reset mid-frame: the FSM returns to IDLE and all queued bytes are discarded. The transmitter's own reset handles the line.
- Write at edge N: `empty`=0 and `count`=1 after N. `send`=1 after edge N+1, so latency from write to request is 1 cycle.
- `send` drops on the same edge that `tx_busy`=1 is sampled. Minimum `send` width is 1 cycle.
- Back-to-back frames: after `tx_busy` falls (sampled at edge M), `send` for the next byte rises after edge M+1.
- `count`/`full`/`empty` update on the edge of the write/pop. There is no combinational path from `wr_en` to `full`.

## Structure
- Shared package `uart_pkg`: `typedef enum logic [1:0] {TXF_IDLE, TXF_LAUNCH, TXF_WAIT_DONE} txf_state_t;` and `localparam UART_DATA_W = 8`.
- One natural sub-module is `sync_fifo_core`, which holds storage, pointers, count and the full/empty/overflow flags. The top level holds the drain FSM and the `tx_data` latch.
- Integration: `send`→`uart_top.send`, `tx_data`→`uart_top.data_in`, `uart_top.tx_busy`→`tx_busy`.

## Test plan
- Reset values: hold `reset`=0 → all outputs at their reset values. Write 0xA5, then assert `reset` in LAUNCH → `send`=0, `empty`=1, `count`=0 immediately.
- Single byte: write 0x55, with the bench model raising `tx_busy` 3 cycles after `send`.
  - Expect `send` high for exactly 3 cycles, `tx_data`=0x55 throughout.
  - Expect `count` to go 1→0 on the `tx_busy`-rise edge.
- Burst: write 0x01..0x04 on consecutive cycles with the real `uart_top` and `CLK_PER_BIT`=4 → serial line carries 0x01, 0x02, 0x03, 0x04 in order, and `send` pulses exactly 4 times.
- Full/overflow with DEPTH=16 and `tx_busy` forced high:
  - 16 writes → `full`=1, `count`=16.
  - 17th write (0xEE) is dropped and `overflow`=1.
  - `ovf_clr` → `overflow`=0.
  - The drained stream contains no 0xEE.
- Wrap and simultaneous access: keep `count` between 3 and 5 over 40 writes/pops, including same-cycle write+pop → pointers wrap twice and the output order matches the input.
- Busy already high: hold `tx_busy`=1 with 2 bytes queued → `send` stays 0. Release it → `send` rises after 1 cycle.
